// File: rtl/mux_tree_tapbuf_cfg.sv
// Self-configuring N_IN:1 routing mux: scan segment plus shadow select, with unused codes forced high.
// Optional registered output when MUX_TREE_OUT_REG_EN is defined.
module mux_tree_tapbuf_cfg #(
    parameter int N_IN = 22,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic [N_IN-1:0]   in,
    input  logic              ccff_head,
    input  logic              cfg_en,
    input  logic              cfg_update,
    output logic              ccff_tail,
    output logic [SEL_W-1:0]  sram,
    output logic [SEL_W-1:0]  sram_inv,
    output logic              sel_invalid,
    output logic              out
);

    localparam int N_PAD = 1 << SEL_W;
    localparam logic [SEL_W-1:0] K_MAX = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] shreg;
    logic [SEL_W-1:0] k;
    logic [N_PAD-1:0] in_ext;
    logic             out_comb;

    // Update reads shreg before the same-edge shift, so both may be asserted together.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shreg <= '0;
            sram  <= '0;
        end else begin
            if (cfg_en)
                shreg <= (shreg << 1) | SEL_W'(ccff_head);
            if (cfg_update)
                sram <= shreg;
        end
    end

    assign ccff_tail = shreg[SEL_W-1];
    assign sram_inv  = ~sram;
    assign k         = ~sram;

    // Codes past the last real input read a constant 1 from the padding.
    always_comb begin
        in_ext = '1;
        in_ext[N_IN-1:0] = in;
    end

    assign out_comb = in_ext[k];

    if (N_IN == N_PAD) begin : g_full
        assign sel_invalid = 1'b0;
    end else begin : g_partial
        assign sel_invalid = (k > K_MAX);
    end

`ifdef MUX_TREE_OUT_REG_EN
    always_ff @(posedge prog_clk) begin
        if (pReset)
            out <= 1'b1;
        else
            out <= out_comb;
    end
`else
    assign out = out_comb;
`endif

endmodule

// File: tb/tb_mux_tree_tapbuf_cfg.sv
// Bench for mux_tree_tapbuf_cfg: directed configuration sequences then random traffic against a numeric model.
module tb_mux_tree_tapbuf_cfg;

    localparam int N_IN  = 22;
    localparam int SEL_W = $clog2(N_IN);
    localparam int SPAN  = 1 << SEL_W;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic [N_IN-1:0]   in_v;
    logic              ccff_head;
    logic              cfg_en;
    logic              cfg_update;
    logic              ccff_tail;
    logic [SEL_W-1:0]  sram;
    logic [SEL_W-1:0]  sram_inv;
    logic              sel_invalid;
    logic              out;

    int n_checks = 0;
    int n_fail   = 0;

    int m_shreg = 0;
    int m_sram  = 0;
    bit m_oreg  = 1'b1;

    mux_tree_tapbuf_cfg #(.N_IN(N_IN)) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .in          (in_v),
        .ccff_head   (ccff_head),
        .cfg_en      (cfg_en),
        .cfg_update  (cfg_update),
        .ccff_tail   (ccff_tail),
        .sram        (sram),
        .sram_inv    (sram_inv),
        .sel_invalid (sel_invalid),
        .out         (out)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_mux(input logic [N_IN-1:0] iv, input int sel);
        int idx;
        idx = SPAN - 1 - sel;
        if (idx < N_IN)
            return iv[idx];
        return 1'b1;
    endfunction

    function automatic bit exp_out_now();
`ifdef MUX_TREE_OUT_REG_EN
        return m_oreg;
`else
        return exp_mux(in_v, m_sram);
`endif
    endfunction

    task automatic check_outputs();
        check_val("ccff_tail", {31'd0, ccff_tail}, (m_shreg >= SPAN / 2) ? 32'd1 : 32'd0);
        check_val("sram", 32'(sram), 32'(m_sram));
        check_val("sram_inv", 32'(sram_inv), 32'(SPAN - 1 - m_sram));
        check_val("sel_invalid", {31'd0, sel_invalid}, ((SPAN - 1 - m_sram) >= N_IN) ? 32'd1 : 32'd0);
        check_val("out", {31'd0, out}, {31'd0, exp_out_now()});
    endtask

    task automatic cycle();
        bit pre_out;
        pre_out = exp_mux(in_v, m_sram);
        @(posedge prog_clk);
        if (pReset) begin
            m_shreg = 0;
            m_sram  = 0;
            m_oreg  = 1'b1;
        end else begin
            if (cfg_update)
                m_sram = m_shreg;
            if (cfg_en)
                m_shreg = (m_shreg * 2 + int'(ccff_head)) % SPAN;
            m_oreg = pre_out;
        end
        #1;
        check_outputs();
    endtask

    task automatic shift_bit(input bit b);
        ccff_head  = b;
        cfg_en     = 1'b1;
        cfg_update = 1'b0;
        cycle();
        cfg_en = 1'b0;
    endtask

    task automatic do_update();
        cfg_en     = 1'b0;
        cfg_update = 1'b1;
        cycle();
        cfg_update = 1'b0;
    endtask

    task automatic set_in_and_check(input logic [N_IN-1:0] v);
        in_v = v;
        #1;
        check_val("out_comb_settle", {31'd0, out}, {31'd0, exp_out_now()});
    endtask

    initial begin
        pReset     = 1'b1;
        in_v       = '0;
        ccff_head  = 1'b0;
        cfg_en     = 1'b0;
        cfg_update = 1'b0;

        // Reset for two cycles.
        cycle();
        cycle();
        check_val("rst_sram", 32'(sram), 32'd0);
        check_val("rst_sram_inv", 32'(sram_inv), 32'd31);
        check_val("rst_out", {31'd0, out}, 32'd1);
        check_val("rst_invalid", {31'd0, sel_invalid}, 32'd1);
        check_val("rst_tail", {31'd0, ccff_tail}, 32'd0);
        pReset = 1'b0;

        // Select in[0]: all ones.
        for (int i = 0; i < SEL_W; i++) shift_bit(1'b1);
        do_update();
        check_val("sel0_sram", 32'(sram), 32'h1f);
        check_val("sel0_invalid", {31'd0, sel_invalid}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            logic [N_IN-1:0] v;
            v = (t % 2 == 0) ? {{(N_IN-1){1'b1}}, 1'b0} : {{(N_IN-1){1'b0}}, 1'b1};
            set_in_and_check(v);
            cycle();
`ifndef MUX_TREE_OUT_REG_EN
            check_val("sel0_track", {31'd0, out}, (t % 2 == 0) ? 32'd0 : 32'd1);
`endif
        end

        // Select in[21].
        shift_bit(0); shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0);
        do_update();
        check_val("sel21_sram", 32'(sram), 32'h0a);
        check_val("sel21_invalid", {31'd0, sel_invalid}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            logic [N_IN-1:0] v;
            v = '0;
            v[21] = (t % 2 == 0);
            if (t % 2 != 0) v = ~v;
            set_in_and_check(v);
            cycle();
        end

        // k = 22: first unused code.
        shift_bit(0); shift_bit(1); shift_bit(0); shift_bit(0); shift_bit(1);
        do_update();
        in_v = '0;
        cycle();
        check_val("k22_out", {31'd0, out}, 32'd1);
        check_val("k22_invalid", {31'd0, sel_invalid}, 32'd1);

        // Chain pass-through with no update.
        shift_bit(1);
        for (int i = 0; i < 4; i++) shift_bit(0);
        check_val("chain_tail5", {31'd0, ccff_tail}, 32'd1);
        shift_bit(0);
        check_val("chain_tail6", {31'd0, ccff_tail}, 32'd0);
        check_val("chain_sram_hold", 32'(sram), 32'h09);

        // Simultaneous shift and update from shreg = 10101.
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0); shift_bit(1);
        ccff_head  = 1'b1;
        cfg_en     = 1'b1;
        cfg_update = 1'b1;
        cycle();
        cfg_en     = 1'b0;
        cfg_update = 1'b0;
        check_val("simul_sram", 32'(sram), 32'h15);

        // Reset mid-shift.
        shift_bit(1); shift_bit(1);
        pReset = 1'b1;
        cfg_en = 1'b1;
        ccff_head = 1'b1;
        cycle();
        pReset = 1'b0;
        cfg_en = 1'b0;
        check_val("midrst_sram", 32'(sram), 32'd0);
        check_val("midrst_tail", {31'd0, ccff_tail}, 32'd0);
        check_val("midrst_out", {31'd0, out}, 32'd1);

`ifdef MUX_TREE_OUT_REG_EN
        // Select in[3]; out lags input by one edge.
        shift_bit(1); shift_bit(1); shift_bit(1); shift_bit(0); shift_bit(0);
        do_update();
        check_val("sel3_sram", 32'(sram), 32'h1c);
        in_v = '0;
        cycle();
        in_v[3] = 1'b1;
        #1;
        check_val("reg_hold", {31'd0, out}, 32'd0);
        cycle();
        check_val("reg_lag", {31'd0, out}, 32'd1);
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            pReset     = ($urandom_range(0, 63) == 0);
            cfg_en     = $urandom_range(0, 1) == 1;
            cfg_update = ($urandom_range(0, 3) == 0);
            ccff_head  = $urandom_range(0, 1) == 1;
            in_v       = N_IN'($urandom);
            cycle();
            if (n % 7 == 0)
                set_in_and_check(N_IN'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
